// File: rtl/motor_pwm_driver_if.sv
// rtl/motor_pwm_driver_if.sv - Speed command and PWM pin bundle between controller and motor driver
interface motor_pwm_driver_if;
  logic       enable;
  logic [6:0] speed_a1_a;
  logic [6:0] speed_b1_a;
  logic [6:0] speed_a1_b;
  logic [6:0] speed_b1_b;
  logic       pwm_a1_a;
  logic       pwm_b1_a;
  logic       pwm_a1_b;
  logic       pwm_b1_b;
  logic       period_start;
  logic       fault;

  modport master (
    output enable, speed_a1_a, speed_b1_a, speed_a1_b, speed_b1_b,
    input  pwm_a1_a, pwm_b1_a, pwm_a1_b, pwm_b1_b, period_start, fault
  );

  modport slave (
    input  enable, speed_a1_a, speed_b1_a, speed_a1_b, speed_b1_b,
    output pwm_a1_a, pwm_b1_a, pwm_a1_b, pwm_b1_b, period_start, fault
  );
endinterface

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - Dual H-bridge PWM driver with period-aligned duty updates and reversal dead time
module motor_pwm_driver #(
  parameter int CLK_DIV      = 50,
  parameter int PWM_STEPS    = 100,
  parameter int DEAD_PERIODS = 2
) (
  input logic clk,
  input logic rst,
  motor_pwm_driver_if.slave ctrl
);
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
  localparam int CMP_W = (PH_W > 7) ? PH_W : 7;
  localparam int DC_W  = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRV1, DRV2, DEAD} state_t;

  logic [PRE_W-1:0] prescaler;
  logic [PH_W-1:0]  phase;
  logic [6:0]       duty [4];
  state_t           state [2];
  logic [DC_W-1:0]  dead_cnt [2];
  logic [3:0]       pin;
  logic             start_q;
  logic             fault_q;

  logic       tick;
  logic       boundary;
  logic [6:0] next_duty [4];
  logic [1:0] dir1;
  logic [1:0] dir2;
  logic [1:0] conflict;

  function automatic logic [6:0] saturate(input logic [6:0] s);
    return (s > 7'd100) ? 7'd100 : s;
  endfunction

  assign tick     = (prescaler == PRE_W'(CLK_DIV - 1));
  assign boundary = tick && (phase == PH_W'(PWM_STEPS - 1));

  always_comb begin
    dir1         = '0;
    dir2         = '0;
    conflict     = '0;
    next_duty[0] = saturate(ctrl.speed_a1_a);
    next_duty[1] = saturate(ctrl.speed_b1_a);
    next_duty[2] = saturate(ctrl.speed_a1_b);
    next_duty[3] = saturate(ctrl.speed_b1_b);
    for (int b = 0; b < 2; b++) begin
      dir1[b]     = (next_duty[2*b] != 7'd0) && (next_duty[2*b+1] == 7'd0);
      dir2[b]     = (next_duty[2*b] == 7'd0) && (next_duty[2*b+1] != 7'd0);
      conflict[b] = (next_duty[2*b] != 7'd0) && (next_duty[2*b+1] != 7'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      phase     <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        phase <= (phase == PH_W'(PWM_STEPS - 1)) ? '0 : phase + 1'b1;
      end
    end
  end

  // Shadow duties, bridge FSMs and pins; commands only take effect at the period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) duty[i] <= '0;
      for (int b = 0; b < 2; b++) begin
        state[b]    <= IDLE;
        dead_cnt[b] <= '0;
      end
      pin     <= '0;
      start_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      start_q <= boundary;
      if (boundary) begin
        for (int i = 0; i < 4; i++) duty[i] <= next_duty[i];
        fault_q <= |conflict;
        for (int b = 0; b < 2; b++) begin
          case (state[b])
            IDLE: begin
              if (dir1[b])      state[b] <= DRV1;
              else if (dir2[b]) state[b] <= DRV2;
            end
            DRV1: begin
              if (dir2[b]) begin
                if (DEAD_PERIODS == 0) begin
                  state[b] <= DRV2;
                end else begin
                  state[b]    <= DEAD;
                  dead_cnt[b] <= DC_W'(DEAD_PERIODS);
                end
              end else if (!dir1[b]) begin
                state[b] <= IDLE;
              end
            end
            DRV2: begin
              if (dir1[b]) begin
                if (DEAD_PERIODS == 0) begin
                  state[b] <= DRV1;
                end else begin
                  state[b]    <= DEAD;
                  dead_cnt[b] <= DC_W'(DEAD_PERIODS);
                end
              end else if (!dir2[b]) begin
                state[b] <= IDLE;
              end
            end
            default: begin
              if (dead_cnt[b] > DC_W'(1)) begin
                dead_cnt[b] <= dead_cnt[b] - 1'b1;
              end else begin
                dead_cnt[b] <= '0;
                state[b]    <= IDLE;
              end
            end
          endcase
        end
      end
      for (int b = 0; b < 2; b++) begin
        pin[2*b]   <= ctrl.enable && (state[b] == DRV1) &&
                      (CMP_W'(phase) < CMP_W'(duty[2*b]));
        pin[2*b+1] <= ctrl.enable && (state[b] == DRV2) &&
                      (CMP_W'(phase) < CMP_W'(duty[2*b+1]));
      end
    end
  end

  assign ctrl.pwm_a1_a     = pin[0];
  assign ctrl.pwm_b1_a     = pin[1];
  assign ctrl.pwm_a1_b     = pin[2];
  assign ctrl.pwm_b1_b     = pin[3];
  assign ctrl.period_start = start_q;
  assign ctrl.fault        = fault_q;
endmodule
